// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential ROM addressing, 1-cycle ROM latency absorption,
// a small show-ahead prefetch queue with valid/ready output, and redirect handling.
module instr_fetch #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LAST_PC    = (2 ** ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] LAST = 32'(LAST_PC);

  typedef enum logic {FETCH, STOP} state_t;

  typedef struct packed {
    logic [31:0]           pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     tag;
  logic            inflight;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  entry_t          mem [DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [CW-1:0]   after_pop;
  logic [CW-1:0]   count_nxt;
  logic [PW-1:0]   rd_nxt;
  entry_t          land;
  entry_t          head_nxt;

  // Issue/push/pop decisions; a redirect suppresses all three.
  always_comb begin
    issue     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    land      = '{pc: tag, instr: rom_q};
    if (!redirect_valid) begin
      issue = (state == FETCH) &&
              (({1'b0, count} + (CW + 1)'(inflight)) < (CW + 1)'(DEPTH));
      push  = inflight;
      pop   = out_valid && out_ready;
    end
    after_pop = count - CW'(pop);
    count_nxt = after_pop + CW'(push);
    rd_nxt    = rd_ptr + PW'(pop);
    // When the queue would otherwise be empty, the landing word becomes the head.
    head_nxt  = (after_pop == '0) ? land : mem[rd_nxt];
  end

  // Queue storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= land;
    end
  end

  // Fetch control, queue pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      fetch_pc  <= '0;
      tag       <= '0;
      inflight  <= 1'b0;
      rom_addr  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      inflight  <= 1'b0;
      fetch_pc  <= redirect_pc;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      if (redirect_pc <= LAST) begin
        state    <= FETCH;
        rom_addr <= redirect_pc[ADDR_WIDTH-1:0];
      end else begin
        state    <= STOP;
      end
    end else begin
      // rom_addr always presents the next address to fetch so the ROM samples it on issue.
      inflight <= issue;
      if (issue) begin
        tag <= fetch_pc;
        if (fetch_pc == LAST) begin
          state <= STOP;
        end else begin
          fetch_pc <= fetch_pc + 32'd1;
          rom_addr <= ADDR_WIDTH'(fetch_pc + 32'd1);
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        out_pc    <= head_nxt.pc;
        out_instr <= head_nxt.instr;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a stream model predicts the pc sequence
// after each reset/redirect and a monitor checks every presented head against it.
module tb_instr_fetch;

  localparam int unsigned LAST = 127;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  rom_addr;
  logic [31:0] rom_q = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          vectors = 0;
  int          miscompares = 0;
  int          since = 0;
  bit          in_reset = 1'b1;
  int unsigned exp_q[$];
  logic [31:0] rom [128];

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_q          (rom_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Delivered stream after a restart at start: start, start+1, ..., LAST (nothing if out of range).
  function automatic void build(input int unsigned start);
    exp_q.delete();
    if (start <= LAST)
      for (int unsigned p = start; p <= LAST; p++) exp_q.push_back(p);
  endfunction

  // Restart model: a redirect sampled on an edge restarts the expected stream.
  always @(posedge clk) begin
    if (rst_n && !in_reset) begin
      if (redirect_valid) begin
        build(redirect_pc);
        since = 1;
      end else if (since < 1000) begin
        since++;
      end
    end
  end

  // Monitor: latency gap, no bubbles while the stream has words left, head contents.
  always @(negedge clk) begin
    if (rst_n && !in_reset) begin
      if (since <= 2) check("restart_gap_valid", 32'(out_valid), 32'd0);
      else if (exp_q.size() > 0) check("stream_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_valid: got pc %0d expected no valid", out_pc);
        end else begin
          check("out_pc", out_pc, exp_q[0]);
          check("out_instr", out_instr, exp_q[0] + 32'd100);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic release_reset();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_pc", out_pc, 32'd0);
    check("reset_out_instr", out_instr, 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    build(0);
    since    = 1;
    in_reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'(i + 100);

    // Power-on reset, then free-running fetch.
    tick(3);
    release_reset();
    tick(20);

    // Stall: queue fills to DEPTH and holds its head, then drains in order.
    out_ready = 1'b0;
    tick(10);
    check("stall_full_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick(12);

    // Redirect while the queue is filling with an issue in flight.
    out_ready = 1'b0;
    tick(3);
    redirect(50);
    out_ready = 1'b1;
    tick(10);

    // Fetch to the end of the ROM and stop.
    redirect(125);
    tick(15);
    check("end_rom_addr", 32'(rom_addr), 32'd127);
    check("end_out_valid", 32'(out_valid), 32'd0);

    // Out-of-range redirect stops fetch; a later redirect resumes.
    redirect(200);
    tick(10);
    check("oor_rom_addr", 32'(rom_addr), 32'd127);
    check("oor_out_valid", 32'(out_valid), 32'd0);
    redirect(3);
    tick(10);

    // Mid-stream reset with words queued.
    out_ready = 1'b0;
    tick(2);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n    = 1'b0;
    in_reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    tick(1);
    out_ready = 1'b1;
    release_reset();
    tick(10);

    // Random ready and redirects.
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom % 4) != 0;
      if (($urandom % 25) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'($urandom_range(0, 140));
      end else begin
        redirect_valid = 1'b0;
      end
      tick(1);
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
